// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: sequences two external line memories as a rotating two-line
// delay. Each accepted pixel in rows 2..HEIGHT-1 yields a registered vertical
// column (rows r-2, r-1, r) at the same x position for the 3x3 window stage.
module line_buf_ctrl #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic [1:0]  o_mem_en,
  output logic [11:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem0_rdata,
  input  logic [7:0]  i_mem1_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_top,
  output logic [7:0]  o_mid,
  output logic [7:0]  o_bot,
  output logic [11:0] o_col,
  output logic [10:0] o_row,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_err
);

  localparam logic [11:0] COL_LAST = 12'(WIDTH - 1);
  localparam logic [10:0] ROW_LAST = 11'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] col, col_nxt;
  logic [10:0] row, row_nxt;
  logic        acc;
  logic        eol;
  logic        out_ld;
  logic        err_nxt;

  // The input is accepted whenever the output slot is empty or being drained.
  assign o_ready     = ~o_valid | i_ready;
  assign acc         = i_valid & o_ready;
  assign eol         = (col == COL_LAST);
  assign o_mem_wdata = i_data;

  // State, column and row counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      col   <= 12'd0;
      row   <= 11'd0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Next-state, counter advance and memory write control.
  // A start-of-frame pixel is always stored as row 0, col 0: address 0 of
  // memory 0, regardless of where the interrupted frame had got to.
  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    o_mem_en   = 2'b00;
    o_mem_addr = col;
    out_ld     = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (acc && i_sof) begin
          o_mem_en   = 2'b01;
          o_mem_addr = 12'd0;
          col_nxt    = 12'd1;
          row_nxt    = 11'd0;
          state_nxt  = FILL;
        end else begin
          state_nxt = IDLE;
        end
      end
      FILL, RUN: begin
        if (acc && i_sof) begin
          o_mem_en   = 2'b01;
          o_mem_addr = 12'd0;
          col_nxt    = 12'd1;
          row_nxt    = 11'd0;
          err_nxt    = 1'b1;
          state_nxt  = FILL;
        end else if (acc) begin
          o_mem_en = row[0] ? 2'b10 : 2'b01;
          out_ld   = (state == RUN);
          if ((state == RUN) && eol && (row == ROW_LAST)) begin
            col_nxt   = 12'd0;
            row_nxt   = 11'd0;
            state_nxt = IDLE;
          end else if (eol) begin
            col_nxt = 12'd0;
            row_nxt = row + 11'd1;
            if ((state == FILL) && (row == 11'd1)) begin
              state_nxt = RUN;
            end else begin
              state_nxt = state;
            end
          end else begin
            col_nxt = col + 12'd1;
          end
        end else begin
          state_nxt = state;
        end
      end
      default: begin
        state_nxt = IDLE;
        col_nxt   = 12'd0;
        row_nxt   = 11'd0;
      end
    endcase
  end

  // Output column register: loads on a RUN accept, drains when downstream takes it.
  // The memory at row[0] still holds row r-2 because this cycle's write lands
  // on the clock edge, after the read data has been sampled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_top   <= 8'd0;
      o_mid   <= 8'd0;
      o_bot   <= 8'd0;
      o_col   <= 12'd0;
      o_row   <= 11'd0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_err <= err_nxt;
      if (out_ld) begin
        o_valid <= 1'b1;
        o_top   <= row[0] ? i_mem1_rdata : i_mem0_rdata;
        o_mid   <= row[0] ? i_mem0_rdata : i_mem1_rdata;
        o_bot   <= i_data;
        o_col   <= col;
        o_row   <= row;
        o_eol   <= eol;
        o_eof   <= eol & (row == ROW_LAST);
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
module tb_line_buf_ctrl;

  localparam int W = 8;
  localparam int H = 4;

  typedef logic [48:0] col_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_valid, i_sof, i_ready;
  logic [7:0]  i_data;
  logic        o_ready, o_valid, o_eol, o_eof, o_err;
  logic [1:0]  o_mem_en;
  logic [11:0] o_mem_addr, o_col;
  logic [7:0]  o_mem_wdata, i_mem0_rdata, i_mem1_rdata, o_top, o_mid, o_bot;
  logic [10:0] o_row;

  logic [7:0] mem0 [0:4095];
  logic [7:0] mem1 [0:4095];

  col_t exp_q[$];
  col_t obs_q[$];
  int   tests = 0;
  int   fails = 0;
  int   err_cnt = 0;
  logic [1:0] en_seen;

  line_buf_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
    .o_ready(o_ready), .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem0_rdata(i_mem0_rdata), .i_mem1_rdata(i_mem1_rdata),
    .o_valid(o_valid), .i_ready(i_ready), .o_top(o_top), .o_mid(o_mid), .o_bot(o_bot),
    .o_col(o_col), .o_row(o_row), .o_eol(o_eol), .o_eof(o_eof), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Line memory models: combinational read, synchronous write.
  assign i_mem0_rdata = mem0[o_mem_addr];
  assign i_mem1_rdata = mem1[o_mem_addr];
  always @(posedge clk) begin
    if (o_mem_en[0]) mem0[o_mem_addr] <= o_mem_wdata;
    if (o_mem_en[1]) mem1[o_mem_addr] <= o_mem_wdata;
  end

  // Output capture: record each column as downstream consumes it.
  always @(negedge clk) begin
    if (rstn && o_valid && i_ready)
      obs_q.push_back({o_top, o_mid, o_bot, o_col, o_row, o_eol, o_eof});
    if (rstn && o_err) err_cnt++;
  end

  function automatic logic [7:0] pix(input int f, input int r, input int c);
    return 8'((f * 64) + (r * 16) + c);
  endfunction

  // Drive one pixel and wait until it is accepted (bounded).
  task automatic put(input logic [7:0] d, input logic sof);
    bit got;
    got = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_sof   = sof;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      en_seen = o_mem_en;
      if (o_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      fails++;
      tests++;
      $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
    end
  endtask

  // Drive pixel (r,c) of frame f; push its expected column when it should produce one.
  task automatic send_px(input int f, input int r, input int c, input logic sof, input bit push);
    if (push && r >= 2)
      exp_q.push_back({pix(f, r - 2, c), pix(f, r - 1, c), pix(f, r, c), 12'(c), 11'(r),
                       1'(c == W - 1), 1'((c == W - 1) && (r == H - 1))});
    put(pix(f, r, c), sof);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_data = 8'd0; i_ready = 1'b1;
    #3;
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", o_ready); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    tests++; if (o_mem_addr !== 12'd0) begin fails++; $display("FAIL rst_addr: got %0d want 0", o_mem_addr); end
    tests++; if (o_mem_en !== 2'b00) begin fails++; $display("FAIL rst_en: got %b want 00", o_mem_en); end
    tests++; if ({o_top, o_mid, o_bot, o_col, o_row, o_eol, o_eof, o_err} !== 50'd0) begin
      fails++; $display("FAIL rst_outs: got %h want 0", {o_top, o_mid, o_bot, o_col, o_row, o_eol, o_eof, o_err});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_idle_drop;
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 10; k++) begin
      put(8'(8'h50 + k), 1'b0);
      tests++; if (en_seen !== 2'b00) begin fails++; $display("FAIL idle_wen: got %b want 00", en_seen); end
    end
    idle(3);
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b want 1", o_ready); end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL idle_out: got %0d columns want 0", obs_q.size()); end
    tests++; if (err_cnt != e0) begin fails++; $display("FAIL idle_err: got %0d pulses want 0", err_cnt - e0); end
  endtask

  task automatic test_continuous;
    col_t e, o;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_px(0, r, c, (r == 0 && c == 0), 1'b1);
        tests++; if (en_seen !== ((r % 2) ? 2'b10 : 2'b01)) begin
          fails++; $display("FAIL cont_wen r%0d c%0d: got %b", r, c, en_seen);
        end
        if (r < 2 || (r == 2 && c == 0)) begin
          tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL cont_prime: got %0d columns want 0", obs_q.size()); end
        end
      end
    end
    idle(3);
    tests++; if (obs_q.size() != 16) begin fails++; $display("FAIL cont_count: got %0d want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL cont_col: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    put(8'h77, 1'b0);
    tests++; if (en_seen !== 2'b00) begin fails++; $display("FAIL cont_idle_after_eof: got %b want 00", en_seen); end
    idle(2);
  endtask

  task automatic test_backpressure;
    col_t e, o;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_px(1, r, c, (r == 0 && c == 0), 1'b1);
        tests++; if (en_seen !== ((r % 2) ? 2'b10 : 2'b01)) begin
          fails++; $display("FAIL rot_wen r%0d c%0d: got %b", r, c, en_seen);
        end
        if (r == 2 && c == 4) begin
          i_ready = 1'b0;
          i_valid = 1'b1;
          i_data  = pix(1, 2, 5);
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b want 0", o_ready); end
            tests++; if (o_mem_en !== 2'b00) begin fails++; $display("FAIL bp_wen: got %b want 00", o_mem_en); end
            tests++; if ({o_valid, o_col, o_bot} !== {1'b1, 12'd4, pix(1, 2, 4)}) begin
              fails++; $display("FAIL bp_hold: got v%b c%0d b%h want v1 c4 b%h", o_valid, o_col, o_bot, pix(1, 2, 4));
            end
            @(posedge clk); #1;
          end
          i_ready = 1'b1;
        end
      end
    end
    idle(3);
    tests++; if (obs_q.size() != 16) begin fails++; $display("FAIL bp_count: got %0d want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL bp_col: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_premature_sof;
    col_t e, o;
    int e0, n0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 4) send_px(2, r, c, (r == 0 && c == 0), 1'b1);
    e0 = err_cnt;
    send_px(3, 0, 0, 1'b1, 1'b1);
    tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL psof_err: got %b want 1", o_err); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL psof_noout: got %b want 0", o_valid); end
    n0 = obs_q.size();
    for (int k = 1; k <= 16; k++) begin
      send_px(3, k / W, k % W, 1'b0, 1'b1);
      if (k == 1) begin
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL psof_pulse: got %b want 0", o_err); end
      end
    end
    tests++; if (obs_q.size() != n0) begin fails++; $display("FAIL psof_prime: got %0d new columns want 0", obs_q.size() - n0); end
    for (int k = 17; k < W * H; k++) send_px(3, k / W, k % W, 1'b0, 1'b1);
    idle(3);
    tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL psof_errcnt: got %0d want 1", err_cnt - e0); end
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL psof_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL psof_col: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midrun;
    for (int k = 0; k < 20; k++) send_px(4, k / W, k % W, (k == 0), 1'b0);
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL mid_valid: got %b want 1", o_valid); end
    #1;
    rstn = 1'b0;
    #1;
    tests++; if ({o_valid, o_ready, o_err, o_eol, o_eof} !== 5'b01000) begin
      fails++; $display("FAIL mid_rst_ctl: got %b want 01000", {o_valid, o_ready, o_err, o_eol, o_eof});
    end
    tests++; if ({o_top, o_mid, o_bot, o_col, o_row, o_mem_addr} !== 59'd0) begin
      fails++; $display("FAIL mid_rst_data: got %h want 0", {o_top, o_mid, o_bot, o_col, o_row, o_mem_addr});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    obs_q.delete(); exp_q.delete();
    put(8'h33, 1'b0);
    tests++; if (en_seen !== 2'b00) begin fails++; $display("FAIL mid_drop: got %b want 00", en_seen); end
    idle(2);
    tests++; if (o_valid !== 1'b0 || obs_q.size() != 0) begin
      fails++; $display("FAIL mid_noout: got v%b n%0d want v0 n0", o_valid, obs_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_drop();
    test_continuous();
    test_backpressure();
    test_premature_sof();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
